// File: rtl/uart_tx_bridge.sv
// -----------------------------------------------------------------------------
// uart_tx_bridge
//
// Buffers DATA_W-bit words from a write strobe in a small FIFO and sends each
// word as DATA_W/8 UART frames (start bit, 8 data bits LSB-first, STOP_BITS
// stop bits), every bit held for BAUD_DIV clocks. Bytes of a word go out
// most-significant first when MSB_FIRST=1, least-significant first otherwise.
// Consecutive bytes and consecutive words follow each other with no idle gap.
//
// Parameters:
//   DATA_W      word width, multiple of 8, 8..64
//   FIFO_DEPTH  buffered words, power of two, >= 2
//   BAUD_DIV    clocks per UART bit, >= 2
//   MSB_FIRST   1: MS byte first, 0: LS byte first
//   STOP_BITS   1 or 2
//
// Ports:
//   CLK       in   system clock, rising edge
//   RESET     in   synchronous, active-high reset
//   DATA_IN   in   word to transmit
//   WR        in   write strobe, one word per cycle while high
//   FULL      out  FIFO holds FIFO_DEPTH words (registered)
//   EMPTY     out  FIFO holds no words (registered)
//   BUSY      out  serialiser is not idle
//   OVERFLOW  out  sticky: a write was dropped since the last reset
//   TX        out  UART line, idles high
// -----------------------------------------------------------------------------
module uart_tx_bridge #(
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int BAUD_DIV   = 5208,
   parameter int MSB_FIRST  = 1,
   parameter int STOP_BITS  = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic              WR,
   output logic              FULL,
   output logic              EMPTY,
   output logic              BUSY,
   output logic              OVERFLOW,
   output logic              TX
);

   localparam int NB  = DATA_W / 8;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int NBW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
   localparam logic [NBW-1:0] NB_LAST   = NBW'(NB - 1);
   // Index of the final stop bit: 0 for one stop bit, 1 for two.
   localparam logic           STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // ---------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     count_d;
   logic              full_q;
   logic              empty_q;
   logic              overflow_q;
   logic [DATA_W-1:0] head_word;
   logic              push;
   logic              pop;

   // ---------------------------------------------------------------------------
   // Serialiser state
   // ---------------------------------------------------------------------------
   state_t            state_q;
   logic [BW-1:0]     baud_q;
   logic [2:0]        bit_q;
   logic              stop_q;
   logic [NBW-1:0]    byte_idx_q;
   logic [DATA_W-1:0] word_q;
   logic [6:0]        shift_q;
   logic              tx_q;
   logic              busy_q;

   logic              baud_end;
   logic              stop_end;
   logic              last_byte;
   logic [7:0]        cur_byte;
   int                byte_sel;

   // The head is read combinationally so the pop edge can load the word
   // register directly and drop TX in the same cycle.
   assign head_word = mem_q[rd_ptr_q];

   assign baud_end  = (baud_q == BAUD_LAST);
   assign last_byte = (byte_idx_q == NB_LAST);
   assign stop_end  = (state_q == S_STOP) && baud_end && (stop_q == STOP_LAST);

   // A word leaves the FIFO either from IDLE or at the end of the last stop
   // bit of the previous word (back-to-back transmission).
   assign pop  = !empty_q && ((state_q == S_IDLE) || (stop_end && last_byte));
   // A pop in the same cycle frees the slot, so a write while full still lands.
   assign push = WR && (!full_q || pop);

   assign count_d = count_q + CW'(push) - CW'(pop);

   always_comb begin
      byte_sel = (MSB_FIRST != 0) ? (NB - 1 - int'(byte_idx_q)) : int'(byte_idx_q);
      cur_byte = 8'(word_q >> (8 * byte_sel));
   end

   // Storage is not reset; pointers and count define which entries are valid.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= DATA_IN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
         if (WR && full_q && !pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Serialiser FSM. TX and BUSY are registered and change on the same edge
   // as the state they belong to.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         stop_q     <= 1'b0;
         byte_idx_q <= '0;
         word_q     <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  word_q     <= head_word;
                  byte_idx_q <= '0;
                  baud_q     <= '0;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_START;
               end else begin
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
               end
            end

            S_START: begin
               if (baud_end) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= cur_byte[0];
                  shift_q <= cur_byte[7:1];
                  state_q <= S_DATA;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end

            S_DATA: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     stop_q  <= 1'b0;
                     tx_q    <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     tx_q    <= shift_q[0];
                     shift_q <= shift_q >> 1;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end

            S_STOP: begin
               if (baud_end) begin
                  baud_q <= '0;
                  if (stop_q != STOP_LAST) begin
                     stop_q <= 1'b1;
                  end else if (!last_byte) begin
                     byte_idx_q <= byte_idx_q + NBW'(1);
                     tx_q       <= 1'b0;
                     state_q    <= S_START;
                  end else if (pop) begin
                     word_q     <= head_word;
                     byte_idx_q <= '0;
                     tx_q       <= 1'b0;
                     state_q    <= S_START;
                  end else begin
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end

            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign FULL     = full_q;
   assign EMPTY    = empty_q;
   assign BUSY     = busy_q;
   assign OVERFLOW = overflow_q;
   assign TX       = tx_q;

endmodule

// File: tb/tb_uart_tx_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_bridge
//
// Two bridge instances with different word width, byte order, stop bits and
// baud divisor share one stimulus stream. For each instance a reference model
// tracks FIFO occupancy, a "transmitter busy for N cycles per word" timer and
// the sticky overflow flag, and queues the expected bytes (on acceptance) and
// frame start cycles (on pop). A monitor decodes every UART frame from TX and
// checks byte value, start cycle and framing against those queues, and checks
// the status flags every cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_bridge;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        WR;
   logic [31:0] DATA_IN;
   bit          done_flag = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   task automatic check(input bit ok, input string nm, input string detail);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: %s", nm, detail);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
      localparam int DW    = (gi == 0) ? 16 : 32;
      localparam int MSB   = (gi == 0) ? 1 : 0;
      localparam int STOPB = (gi == 0) ? 1 : 2;
      localparam int BAUD  = (gi == 0) ? 4 : 3;
      localparam int DEPTH = 4;
      localparam int NB    = DW / 8;
      localparam int FRAME = (9 + STOPB) * BAUD;

      logic full, empty, busy, ovf, tx;

      uart_tx_bridge #(
         .DATA_W    (DW),
         .FIFO_DEPTH(DEPTH),
         .BAUD_DIV  (BAUD),
         .MSB_FIRST (MSB),
         .STOP_BITS (STOPB)
      ) dut (
         .CLK     (CLK),
         .RESET   (RESET),
         .DATA_IN (DATA_IN[DW-1:0]),
         .WR      (WR),
         .FULL    (full),
         .EMPTY   (empty),
         .BUSY    (busy),
         .OVERFLOW(ovf),
         .TX      (tx)
      );

      // Reference model state
      logic [7:0] exp_bytes[$];
      int         exp_start[$];
      int         m_cnt       = 0;
      int         m_busy_left = 0;
      bit         m_ovf       = 1'b0;
      int         m_cyc       = 0;
      int         m_gen       = 0;

      initial begin : model
         logic [DW-1:0] w;
         bit            pop;
         int            idx;
         forever begin
            @(posedge CLK);
            m_cyc++;
            if (RESET === 1'b1) begin
               exp_bytes.delete();
               exp_start.delete();
               m_cnt       = 0;
               m_busy_left = 0;
               m_ovf       = 1'b0;
               m_gen++;
            end else begin
               if (m_busy_left > 0) m_busy_left--;
               pop = (m_busy_left == 0) && (m_cnt > 0);
               if (pop) begin
                  m_busy_left = NB * FRAME;
                  for (int k = 0; k < NB; k++) exp_start.push_back(m_cyc + k * FRAME);
               end
               if (WR === 1'b1) begin
                  if (m_cnt < DEPTH || pop) begin
                     w = DATA_IN[DW-1:0];
                     m_cnt++;
                     for (int k = 0; k < NB; k++) begin
                        idx = (MSB != 0) ? (NB - 1 - k) : k;
                        exp_bytes.push_back(w[idx*8 +: 8]);
                     end
                  end else begin
                     m_ovf = 1'b1;
                  end
               end
               if (pop) m_cnt--;
            end
         end
      end

      initial begin : monitor
         int         seen_gen;
         bit         in_fr;
         int         k;
         int         st;
         int         b;
         bit         glitch;
         bit         stop_ok;
         logic [15:0] bits;
         logic [3:0] got_f;
         logic [3:0] exp_f;
         logic [7:0] eb;
         int         es;
         seen_gen = 0;
         in_fr    = 1'b0;
         k = 0; st = 0; glitch = 1'b0; bits = '0;
         forever begin
            @(negedge CLK);
            got_f = {full, empty, busy, ovf};
            exp_f = {m_cnt == DEPTH, m_cnt == 0, m_busy_left > 0, m_ovf};
            check(got_f === exp_f, $sformatf("flags%0d", gi),
                  $sformatf("cycle %0d FULL/EMPTY/BUSY/OVERFLOW got %b required %b", m_cyc, got_f, exp_f));
            if (m_busy_left == 0)
               check(tx === 1'b1, $sformatf("tx_idle%0d", gi),
                     $sformatf("cycle %0d TX got %b required 1", m_cyc, tx));
            if (m_gen != seen_gen) begin
               seen_gen = m_gen;
               in_fr    = 1'b0;
            end
            if (!in_fr && tx === 1'b0) begin
               in_fr = 1'b1; k = 0; st = m_cyc; glitch = 1'b0; bits = '0;
            end
            if (in_fr) begin
               b = k / BAUD;
               if (k % BAUD == 0) bits[b] = tx;
               else if (tx !== bits[b]) glitch = 1'b1;
               if (k == FRAME - 1) begin
                  in_fr   = 1'b0;
                  stop_ok = 1'b1;
                  for (int s = 0; s < STOPB; s++) stop_ok &= (bits[9+s] === 1'b1);
                  if (exp_bytes.size() == 0 || exp_start.size() == 0) begin
                     check(1'b0, $sformatf("frame%0d", gi),
                           $sformatf("unexpected frame byte %h at cycle %0d, required none", bits[8:1], st));
                  end else begin
                     eb = exp_bytes.pop_front();
                     es = exp_start.pop_front();
                     check((bits[8:1] === eb) && (st == es) && (bits[0] === 1'b0) && stop_ok && !glitch,
                           $sformatf("frame%0d", gi),
                           $sformatf("got byte %h start %0d start_bit %b stop_ok %0d glitch %0d, required byte %h start %0d",
                                     bits[8:1], st, bits[0], stop_ok, glitch, eb, es));
                  end
               end else begin
                  k++;
               end
            end
         end
      end

      initial begin : drain_check
         wait (done_flag);
         check(exp_bytes.size() == 0, $sformatf("drain%0d", gi),
               $sformatf("pending bytes got %0d required 0", exp_bytes.size()));
      end
   end

   function automatic bit all_idle();
      return (g_cfg[0].m_busy_left == 0) && (g_cfg[0].m_cnt == 0) &&
             (g_cfg[1].m_busy_left == 0) && (g_cfg[1].m_cnt == 0);
   endfunction

   task automatic wait_idle(input int limit);
      int n = 0;
      while (!all_idle() && n < limit) begin
         @(negedge CLK);
         n++;
      end
      check(all_idle(), "idle_timeout", $sformatf("idle after %0d cycles got %0d required 1", n, all_idle()));
      repeat (3) @(negedge CLK);
   endtask

   task automatic write_word(input logic [31:0] d);
      @(negedge CLK);
      WR      = 1'b1;
      DATA_IN = d;
      @(negedge CLK);
      WR      = 1'b0;
      DATA_IN = $urandom;
   endtask

   task automatic burst(input int n);
      @(negedge CLK);
      for (int i = 0; i < n; i++) begin
         WR      = 1'b1;
         DATA_IN = $urandom;
         @(negedge CLK);
      end
      WR = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
   endtask

   initial begin : stimulus
      int n;
      RESET   = 1'b1;
      WR      = 1'b0;
      DATA_IN = '0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;

      // Single words, including the classic patterns
      write_word(32'hDEAD_A55A);
      wait_idle(2000);
      write_word(32'hDEAD_BEEF);
      wait_idle(2000);
      write_word(32'h5678_1234);
      wait_idle(2000);

      // Six back-to-back writes into a four-deep FIFO: the sixth is dropped
      burst(6);
      wait_idle(4000);

      // Reset in the middle of byte 0's data bits, then a fresh word
      write_word(32'h1357_9BDF);
      repeat (8) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      write_word(32'h0000_00FF);
      wait_idle(2000);

      // Write while full exactly on the cycle instance 0 pops
      pulse_reset();
      burst(5);
      n = 0;
      while (!(g_cfg[0].m_busy_left == 1 && g_cfg[0].m_cnt == 4) && n < 300) begin
         @(negedge CLK);
         n++;
      end
      check(n < 300, "full_pop_wait", $sformatf("waited %0d cycles, required < 300", n));
      WR      = 1'b1;
      DATA_IN = 32'hC0DE_F00D;
      @(negedge CLK);
      WR = 1'b0;
      wait_idle(4000);

      // Random traffic
      pulse_reset();
      for (int i = 0; i < 900; i++) begin
         WR      = ($urandom_range(0, 24) == 0);
         DATA_IN = $urandom;
         @(negedge CLK);
      end
      WR = 1'b0;
      wait_idle(6000);

      done_flag = 1'b1;
      repeat (2) @(negedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_bridge.md
Name: uart_tx_bridge

Overview:
Parametrised successor to the accumulator-to-serial interface. It accepts DATA_W-bit words from the processor's write strobe and buffers them in an internal FIFO of configurable depth. Each word is split into DATA_W/8 bytes, and each byte is sent as an 8N1 or 8N2 UART frame at a fixed baud divisor. It sits between the BIP core's accumulator output and the board TX pin, and adds status flags plus overflow detection.

Parameters:
DATA_W, 16, word width; must be a multiple of 8, range 8..64.
FIFO_DEPTH, 8, number of buffered words; power of two, at least 2.
BAUD_DIV, 5208, clocks per UART bit (50 MHz / 9600); at least 2.
MSB_FIRST, 1, byte order: 1 sends the most significant byte of a word first, 0 sends the least significant byte first.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
DATA_IN  in  DATA_W  word to transmit.
WR  in  1  write strobe; one word is captured per cycle when WR is high.
FULL  out  1  FIFO holds FIFO_DEPTH words.
EMPTY  out  1  FIFO holds 0 words.
BUSY  out  1  serialiser is outside IDLE.
OVERFLOW  out  1  sticky flag: a write was dropped.
TX  out  1  UART line; idles high.

Behaviour:
- One clock domain and one clock (CLK). RESET is synchronous and active-high.
- While RESET is high at a rising edge:
  - TX=1, FULL=0, EMPTY=1, BUSY=0, OVERFLOW=0.
  - FIFO pointers and count are cleared; stored contents are don't-care.
  - Baud counter, bit counter and byte counter are cleared; the FSM goes to IDLE.
- Reset in mid-frame aborts the frame: TX is high from the next edge and no partial byte is resumed.
- FIFO write rule: WR is accepted if FULL=0, or if a pop occurs in the same cycle.
- FIFO overflow: WR while FULL=1 with no pop drops the word and sets OVERFLOW. OVERFLOW stays set until RESET.
- FULL and EMPTY are registered and reflect the count after the current edge.
- Serialiser FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - TX=1.
  - If EMPTY=0, pop the head word into the word register, select the first byte per MSB_FIRST, go to START, and drive TX=0 at the same edge.
- START: hold TX=0 for BAUD_DIV clocks, then go to DATA with TX = bit 0 of the byte.
- DATA: send 8 bits LSB-first, each held for BAUD_DIV clocks; after bit 7, go to STOP with TX=1.
- STOP: hold TX=1 for STOP_BITS*BAUD_DIV clocks. At the end of the stop bits:
  - If bytes remain in the word: select the next byte and go to START (no idle gap).
  - Else if EMPTY=0: pop the next word and go to START (back-to-back words).
  - Else: go to IDLE.
- Latency: WR high at edge E0 → TX falls at E1 (when the FSM is idle).
- Frame length: (9+STOP_BITS)*BAUD_DIV clocks per byte. A word takes DATA_W/8 frames.
- BUSY=0 only in IDLE.
- Baud counter counts 0..BAUD_DIV-1 and wraps. FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- DATA_IN that is not sampled is ignored. Changing DATA_IN after it is captured has no effect on transmission.

Test Plan:
1. DATA_W=16, BAUD_DIV=4, MSB_FIRST=1, STOP_BITS=1; write 16'hA55A at E0 → TX falls at E1. TX then sends A5 as 0,1,0,1,0,0,1,0,1,1, then 5A as 0,0,1,0,1,1,0,1,0,1, each bit 4 clocks. BUSY=1 for 80 clocks, then TX=1 and BUSY=0.
2. Same configuration with MSB_FIRST=0; write 16'h1234 → byte 34 is sent before byte 12. With STOP_BITS=2 the frame is 44 clocks.
3. FIFO_DEPTH=4; WR high with words W0..W5 on E0..E5 → W0 is popped at E1 and FULL=1 after E4. W5 is dropped and OVERFLOW=1 after E5. TX carries W0..W4 in order with no idle gaps; OVERFLOW stays 1 afterwards.
4. Assert RESET for 1 cycle in the middle of a DATA bit of byte 0 → TX=1, EMPTY=1, BUSY=0, OVERFLOW=0 after that edge. A new write of 16'h00FF afterwards transmits correctly from its start bit.
5. Write while FULL=1 in the same cycle the FSM pops → the word is accepted, OVERFLOW stays 0, and the count is unchanged.
6. DATA_W=32, MSB_FIRST=1; write 32'hDEADBEEF → bytes DE, AD, BE, EF are sent back to back in 160 clocks at BAUD_DIV=4.
